alu_decode_stage: RTL and testbench
===================================

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 The block SHALL have parameter PC_W, default 32, giving the width of the PC carried alongside each instruction.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL be updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning an upstream instruction beat is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit, meaning the stage accepts the beat this cycle.
REQ-006 The block SHALL have port in_instr, input, 32 bits, the RV32 instruction word.
REQ-007 The block SHALL have port in_pc, input, PC_W bits, the instruction PC, carried through unchanged.
REQ-008 The block SHALL have port flush, input, 1 bit, which discards all held and incoming beats.
REQ-009 The block SHALL have port out_valid, output, 1 bit, meaning a decoded beat is present.
REQ-010 The block SHALL have port out_ready, input, 1 bit, meaning downstream accepts the beat.
REQ-011 The block SHALL have port out_alu_op, output, 3 bits, the ALU operation: ADD=000, SUB=001, AND=010, OR=011, XOR=100, SLT=101, SLTU=110.
REQ-012 The block SHALL have port out_use_imm, output, 1 bit, meaning ALU operand b is out_imm rather than rs2 data.
REQ-013 The block SHALL have port out_imm, output, 32 bits, the decoded immediate.
REQ-014 The block SHALL have ports out_rs1, out_rs2 and out_rd, outputs, 5 bits each, the register indices.
REQ-015 The block SHALL have port out_pc, output, PC_W bits, the PC of the decoded instruction.
REQ-016 The block SHALL have port out_illegal, output, 1 bit, meaning the instruction is not executable on the ALU.

Function
REQ-017 A beat SHALL transfer on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
REQ-018 Latency from input transfer to out_valid SHALL be exactly 1 cycle.
REQ-019 All out_* payload SHALL be registered and SHALL stay stable while out_valid && !out_ready.
REQ-020 Opcode 0110011 (R-type) SHALL decode as: funct3 000 with funct7 0000000 -> ADD; funct3 000 with funct7 0100000 -> SUB; funct3 111 -> AND; 110 -> OR; 100 -> XOR; 010 -> SLT; 011 -> SLTU; out_use_imm=0.
REQ-021 For R-type funct3 111/110/100/010/011, funct7 SHALL be 0000000; any other funct7, or any other funct3/funct7 combination, SHALL be illegal.
REQ-022 Opcode 0010011 (I-type) SHALL decode funct3 000/111/110/100/010/011 as ADD/AND/OR/XOR/SLT/SLTU, with out_use_imm=1 and out_imm = sign-extended instr[31:20].
REQ-023 I-type funct3 001 and 101 (shifts) SHALL be illegal, because the ALU has no shifter.
REQ-024 Opcode 0110111 (LUI) SHALL decode as ADD with out_rs1=0, out_use_imm=1 and out_imm={instr[31:12],12'h000}.
REQ-025 Every other opcode SHALL be illegal.
REQ-026 An illegal beat SHALL still be passed downstream, with out_illegal=1, out_alu_op=ADD, out_rd=0, out_imm=0 and out_use_imm=0.
REQ-027 out_rs1, out_rs2 and out_rd SHALL be instr[19:15], instr[24:20] and instr[11:7] unless overridden by REQ-024 or REQ-026.
REQ-028 For non-R-type instructions, out_rs2 SHALL be 0.
REQ-029 When flush=1, the stage SHALL be empty (out_valid=0) on the next cycle.
REQ-030 A beat presented in the same cycle as flush SHALL be discarded.
REQ-031 in_ready SHALL be 0 while flush=1.
REQ-032 Simultaneous input and output transfer on a full single-entry stage SHALL replace the entry with no bubble.

Reset
REQ-033 While rst_n=0, out_valid SHALL be 0, the skid entry (if present) SHALL be empty, and all payload registers SHALL be 0.
REQ-034 Reset asserted mid-transfer SHALL drop all beats.
REQ-035 in_ready SHALL be 0 during reset and SHALL be 1 on the first cycle after release.

Configuration
REQ-036 When macro ALU_DEC_SKID_EN is defined, the block SHALL add a one-entry skid buffer with in_ready = !skid_full, so that in_ready is registered and has no combinational path from out_ready.
REQ-037 With ALU_DEC_SKID_EN defined, a beat accepted while out_valid && !out_ready SHALL be held in the skid entry and SHALL move to the output when the current output beat transfers.
REQ-038 When ALU_DEC_SKID_EN is undefined, the block SHALL use a single output register with in_ready = !out_valid || out_ready.

Structure
REQ-039 Package alu_pkg SHALL hold the ALU op constants (shared with the ALU) and the opcode constants OPC_OP=0110011, OPC_OPIMM=0010011 and OPC_LUI=0110111.
REQ-040 Decode SHALL be a pure function in alu_pkg.
REQ-041 The skid buffer SHALL be sub-module alu_dec_skid, instantiated only under ALU_DEC_SKID_EN.

Verification
REQ-042 The bench SHALL drive 0x002081B3 and then 0x402081B3 -> op 000 then 001, with rs1=1, rs2=2, rd=3, use_imm=0, each 1 cycle after acceptance.
REQ-043 The bench SHALL drive 0xFFF00293 (ADDI x5,x0,-1) -> op 000, imm 0xFFFFFFFF, rd=5, use_imm=1.
REQ-044 The bench SHALL drive 0x123450B7 (LUI x1) -> op 000, rs1=0, imm 0x12345000, rd=1.
REQ-045 The bench SHALL drive 0x00109093 (SLLI) and 0x0000006F (JAL) -> out_illegal=1, rd=0, op 000.
REQ-046 The bench SHALL hold out_ready=0 for 3 cycles with in_valid=1 -> with skid, in_ready falls after 2 acceptances; without skid, after 1; no beat is lost or duplicated.
REQ-047 The bench SHALL assert flush, and separately drop rst_n, while the stage is full and a new beat is presented -> out_valid=0 next cycle, and neither beat appears afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU op constants, RV32 opcode constants and the pure decode function
// used by alu_decode_stage.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLTU = 3'b110
  } alu_op_e;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  typedef struct packed {
    logic        illegal;
    alu_op_e     alu_op;
    logic        use_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } dec_t;

  localparam int DEC_W = $bits(dec_t);

  function automatic dec_t alu_decode(input logic [31:0] instr);
    dec_t       d;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc       = instr[6:0];
    f3        = instr[14:12];
    f7        = instr[31:25];
    d.illegal = 1'b0;
    d.alu_op  = ALU_ADD;
    d.use_imm = 1'b0;
    d.imm     = 32'h0000_0000;
    d.rs1     = instr[19:15];
    d.rs2     = 5'd0;
    d.rd      = instr[11:7];
    case (opc)
      OPC_OP: begin
        d.rs2 = instr[24:20];
        case (f3)
          3'b000:  d.alu_op = (f7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
          3'b111:  d.alu_op = ALU_AND;
          3'b110:  d.alu_op = ALU_OR;
          3'b100:  d.alu_op = ALU_XOR;
          3'b010:  d.alu_op = ALU_SLT;
          3'b011:  d.alu_op = ALU_SLTU;
          default: d.illegal = 1'b1;
        endcase
        // only ADD/SUB may carry a non-zero funct7, and only 0100000
        if ((f7 != 7'b0000000) && !((f3 == 3'b000) && (f7 == 7'b0100000))) begin
          d.illegal = 1'b1;
        end
      end
      OPC_OPIMM: begin
        d.use_imm = 1'b1;
        d.imm     = {{20{instr[31]}}, instr[31:20]};
        case (f3)
          3'b000:  d.alu_op = ALU_ADD;
          3'b111:  d.alu_op = ALU_AND;
          3'b110:  d.alu_op = ALU_OR;
          3'b100:  d.alu_op = ALU_XOR;
          3'b010:  d.alu_op = ALU_SLT;
          3'b011:  d.alu_op = ALU_SLTU;
          default: d.illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        d.rs1     = 5'd0;
        d.use_imm = 1'b1;
        d.imm     = {instr[31:12], 12'h000};
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.illegal) begin
      d.alu_op  = ALU_ADD;
      d.rd      = 5'd0;
      d.imm     = 32'h0000_0000;
      d.use_imm = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_dec_skid.sv
// Two-register elastic stage (output register plus one skid entry); in_ready
// depends only on the skid state, flush and reset, never on out_ready.
module alu_dec_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_out_v;
  logic         r_skid_v;
  logic [W-1:0] r_out_d;
  logic [W-1:0] r_skid_d;
  logic         w_in_fire;
  logic         w_out_fire;

  assign in_ready   = rst_n && !flush && !r_skid_v;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_v && out_ready;
  assign out_valid  = r_out_v;
  assign out_data   = r_out_d;

  // Output register refills from the skid entry first so beat order is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_v  <= 1'b0;
      r_skid_v <= 1'b0;
      r_out_d  <= {W{1'b0}};
      r_skid_d <= {W{1'b0}};
    end else if (flush) begin
      r_out_v  <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (!r_out_v || w_out_fire) begin
      if (r_skid_v) begin
        r_out_v  <= 1'b1;
        r_out_d  <= r_skid_d;
        r_skid_v <= 1'b0;
      end else if (w_in_fire) begin
        r_out_v <= 1'b1;
        r_out_d <= in_data;
      end else begin
        r_out_v <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid_v <= 1'b1;
      r_skid_d <= in_data;
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// RV32 ALU decode pipeline stage with valid/ready handshake on both sides.
// Define ALU_DEC_SKID_EN to add a skid entry and make in_ready registered.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_alu_op,
  output logic            out_use_imm,
  output logic [31:0]     out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [PC_W-1:0] out_pc,
  output logic            out_illegal
);

  localparam int PAY_W = DEC_W + PC_W;

  dec_t             w_dec_in;
  dec_t             w_dec_out;
  logic [PAY_W-1:0] w_pay_in;
  logic [PAY_W-1:0] w_pay_out;
  logic             w_out_valid;

  assign w_dec_in = alu_decode(in_instr);
  assign w_pay_in = {w_dec_in, in_pc};

`ifdef ALU_DEC_SKID_EN
  alu_dec_skid #(.W(PAY_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_pay_in),
    .out_valid (w_out_valid),
    .out_ready (out_ready),
    .out_data  (w_pay_out)
  );
`else
  logic             r_valid;
  logic [PAY_W-1:0] r_pay;
  logic             w_in_fire;

  assign in_ready  = rst_n && !flush && (!r_valid || out_ready);
  assign w_in_fire = in_valid && in_ready;

  // Single output register; a new beat replaces a departing one without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pay   <= {PAY_W{1'b0}};
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_valid <= 1'b1;
      r_pay   <= w_pay_in;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign w_out_valid = r_valid;
  assign w_pay_out   = r_pay;
`endif

  assign w_dec_out   = dec_t'(w_pay_out[PAY_W-1:PC_W]);
  assign out_valid   = w_out_valid;
  assign out_pc      = w_pay_out[PC_W-1:0];
  assign out_alu_op  = w_dec_out.alu_op;
  assign out_use_imm = w_dec_out.use_imm;
  assign out_imm     = w_dec_out.imm;
  assign out_rs1     = w_dec_out.rs1;
  assign out_rs2     = w_dec_out.rs2;
  assign out_rd      = w_dec_out.rd;
  assign out_illegal = w_dec_out.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: table-driven decode model plus a
// beat queue checked every cycle, and literal checks on hand-decoded words.
module tb_alu_decode_stage;

  localparam int PC_W = 32;
`ifdef ALU_DEC_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  // Legal R-type encodings {funct7, funct3, op} and I-type {funct3, op}
  localparam logic [7*13-1:0] R_TAB = {
    7'h00, 3'd0, 3'd0,  7'h20, 3'd0, 3'd1,  7'h00, 3'd7, 3'd2,  7'h00, 3'd6, 3'd3,
    7'h00, 3'd4, 3'd4,  7'h00, 3'd2, 3'd5,  7'h00, 3'd3, 3'd6};
  localparam logic [6*6-1:0] I_TAB = {
    3'd0, 3'd0,  3'd7, 3'd2,  3'd6, 3'd3,  3'd4, 3'd4,  3'd2, 3'd5,  3'd3, 3'd6};

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instr = 32'h0;
  logic [PC_W-1:0] in_pc = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [2:0]      out_alu_op;
  logic            out_use_imm;
  logic [31:0]     out_imm;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  logic [PC_W-1:0] out_pc;
  logic            out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        ill;
    logic [2:0]  op;
    logic        ui;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  alu_decode_stage #(.PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_alu_op(out_alu_op), .out_use_imm(out_use_imm),
    .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_pc(out_pc), .out_illegal(out_illegal)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc);
    exp_t        e;
    logic [12:0] re;
    logic [5:0]  ie;
    e.pc = pc; e.rs1 = instr[19:15]; e.rs2 = 5'd0; e.rd = instr[11:7];
    e.ill = 1'b1; e.op = 3'd0; e.ui = 1'b0; e.imm = 32'h0;
    if (instr[6:0] == 7'h33) begin
      e.rs2 = instr[24:20];
      for (int i = 0; i < 7; i++) begin
        re = R_TAB[i*13 +: 13];
        if ({instr[31:25], instr[14:12]} == re[12:3]) begin e.ill = 1'b0; e.op = re[2:0]; end
      end
    end else if (instr[6:0] == 7'h13) begin
      for (int i = 0; i < 6; i++) begin
        ie = I_TAB[i*6 +: 6];
        if (instr[14:12] == ie[5:3]) begin
          e.ill = 1'b0; e.op = ie[2:0]; e.ui = 1'b1; e.imm = 32'($signed(instr[31:20]));
        end
      end
    end else if (instr[6:0] == 7'h37) begin
      e.ill = 1'b0; e.rs1 = 5'd0; e.ui = 1'b1; e.imm = instr & 32'hFFFF_F000;
    end
    if (e.ill) begin e.rd = 5'd0; e.imm = 32'h0; e.ui = 1'b0; e.op = 3'd0; end
    return e;
  endfunction

  // Compare process: occupancy, handshake and head-of-queue payload every cycle.
  always @(negedge clk) begin
    logic exp_rdy;
    if (!rst_n) begin
      chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
      chk("rst_in_ready", 64'(in_ready), 64'(1'b0));
      chk("rst_payload", {out_pc, out_imm}, 64'h0);
      q.delete();
    end else begin
      if (DEPTH == 2) exp_rdy = !flush && (q.size() < 2);
      else            exp_rdy = !flush && ((q.size() == 0) || out_ready);
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (out_valid && (q.size() != 0)) begin
        chk("ctl", 64'({out_illegal, out_alu_op, out_use_imm, out_rs1, out_rs2, out_rd}),
            64'({q[0].ill, q[0].op, q[0].ui, q[0].rs1, q[0].rs2, q[0].rd}));
        chk("imm", 64'(out_imm), 64'(q[0].imm));
        chk("pc", 64'(out_pc), 64'(q[0].pc));
        if (out_ready) void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(model(in_instr, in_pc));
    end
  end

  // Present one beat and hold it until accepted (bounded); in_valid stays 1.
  task automatic present(input logic [31:0] instr, input logic [31:0] pc, input string name);
    int n = 0;
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk); n++;
    end
    if (!in_ready) chk({name, "_accept_timeout"}, 64'(1'b0), 64'(1'b1));
    @(posedge clk); #1;
  endtask

  task automatic send_check(input logic [31:0] instr, input logic [31:0] pc, input string name,
                            input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic ui, input logic [31:0] imm,
                            input logic ill);
    out_ready = 1'b1;
    present(instr, pc, name);
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, 64'(out_valid), 64'(1'b1));
    chk({name, "_ctl"}, 64'({out_illegal, out_alu_op, out_use_imm, out_rs1, out_rs2, out_rd}),
        64'({ill, op, ui, rs1, rs2, rd}));
    chk({name, "_imm"}, 64'(out_imm), 64'(imm));
    chk({name, "_pc"}, 64'(out_pc), 64'(pc));
    @(posedge clk); #1;
  endtask

  logic [31:0] stream [12] = '{
    32'h0020F1B3, 32'h0020E1B3, 32'h0020C1B3, 32'h0020A1B3, 32'h0020B1B3, 32'h4020F1B3,
    32'h0FF0F093, 32'hFFF0B113, 32'h4010D093, 32'h00002083, 32'h002091B3, 32'h800000B7};

  initial begin
    int acc;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_release", 64'(in_ready), 64'(1'b1));
    @(posedge clk); #1;

    send_check(32'h002081B3, 32'h0000_1000, "add", 3'd0, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, 1'b0);
    send_check(32'h402081B3, 32'h0000_1004, "sub", 3'd1, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, 1'b0);
    send_check(32'hFFF00293, 32'h0000_1008, "addi", 3'd0, 5'd0, 5'd0, 5'd5, 1'b1, 32'hFFFF_FFFF, 1'b0);
    send_check(32'h123450B7, 32'h0000_100C, "lui", 3'd0, 5'd0, 5'd0, 5'd1, 1'b1, 32'h1234_5000, 1'b0);
    send_check(32'h00109093, 32'h0000_1010, "slli", 3'd0, 5'd1, 5'd0, 5'd0, 1'b0, 32'h0, 1'b1);
    send_check(32'h0000006F, 32'h0000_1014, "jal", 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b1);

    // Back-to-back stream with a directed out_ready pattern
    for (int i = 0; i < 12; i++) begin
      present(stream[i], 32'h2000 + 32'(i * 4), "stream");
      out_ready = (i % 3) != 1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Downstream stall with a continuous input stream
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0020F1B3; in_pc = 32'h3000;
    acc = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
      if (acc > 0) begin in_instr = 32'h0020E1B3 + 32'(acc << 7); in_pc = 32'h3000 + 32'(acc * 4); end
    end
    chk("stall_accepts", 64'(acc), 64'(DEPTH));
    @(negedge clk);
    chk("stall_in_ready", 64'(in_ready), 64'(1'b0));
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("stall_drained", 64'(out_valid), 64'(1'b0));

    // Flush while full and a new beat is presented
    @(posedge clk); #1 out_ready = 1'b0;
    present(32'h002081B3, 32'h4000, "flush_fill");
    in_instr = 32'h402081B3; in_pc = 32'h4004; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_empty", 64'(out_valid), 64'(1'b0));
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("flush_no_ghost", 64'(out_valid), 64'(1'b0));

    // Reset while full and a new beat is presented
    @(posedge clk); #1 out_ready = 1'b0;
    present(32'hFFF00293, 32'h5000, "rst_fill");
    in_instr = 32'h123450B7; in_pc = 32'h5004; rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_empty", 64'(out_valid), 64'(1'b0));
    @(posedge clk); #1 rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 64'(in_ready), 64'(1'b1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_no_ghost", 64'(out_valid), 64'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
